// File: rtl/aes_pkg.sv
// aes_pkg: shared AES material for the key schedule and the cipher datapath.
// Holds the key-schedule FSM state type, key/round-count constants,
// the forward S-box table and the GF(2^8) xtime helper.
package aes_pkg;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    WRITE,
    DONE
  } ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_sub_word.sv
// key_sub_word: combinational SubWord with optional RotWord in front.
// Four parallel S-box lookups; the cipher reuses this for SubBytes columns.
module key_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic        rot_i,
  output logic [31:0] word_o
);

  logic [31:0] rotWord;

  assign rotWord = rot_i ? {word_i[23:0], word_i[31:24]} : word_i;

  // Substitute each byte of the (optionally rotated) word independently.
  always_comb begin
    word_o = '0;
    for (int b = 0; b < 4; b++) begin
      word_o[8*b +: 8] = SBOX[rotWord[8*b +: 8]];
    end
  end

endmodule

// File: rtl/key_schedule_gen.sv
// key_schedule_gen: AES-128/192/256 key expansion, one word per cycle,
// each finished round key written to SRAM at BASE_ADDR + 16*r.
// Optional macro KEY_SCHED_ZEROIZE_EN: wipe key window, round buffer and
// Rcon in DONE so no key material survives completion.
module key_schedule_gen
  import aes_pkg::*;
#(
  parameter int KEY_BITS  = 128,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                sram_ready,
  output logic                sram_write,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [127:0]        sram_write_value,
  output logic [3:0]          round_num,
  output logic                busy,
  output logic                done
);

  localparam int NK = (KEY_BITS == 256) ? NK_256 : (KEY_BITS == 192) ? NK_192 : NK_128;
  localparam int NR = (KEY_BITS == 256) ? NR_256 : (KEY_BITS == 192) ? NR_192 : NR_128;
  localparam logic [5:0] LAST_IDX = 6'(4 * NR + 3);
  localparam logic [5:0] NK_IDX   = 6'(NK);
  localparam logic [2:0] NK_LAST  = 3'(NK - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : gen_bad_key_bits
    $error("key_schedule_gen: KEY_BITS must be 128, 192 or 256");
  end

  ks_state_e           state_q, state_d;
  logic [5:0]          wordIdx_q, wordIdx_d;
  logic [2:0]          modIdx_q, modIdx_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [KEY_BITS-1:0] keyWin_q, keyWin_d;
  logic [127:0]        rkBuf_q, rkBuf_d;

  logic [31:0] oldWord;
  logic [31:0] prevWord;
  logic [31:0] subOut;
  logic [31:0] newWord;
  logic        firstPass;
  logic        rotSel;

  // Window holds the last Nk words: oldest (w[i-Nk]) at the top, newest (w[i-1]) at the bottom.
  assign oldWord   = keyWin_q[KEY_BITS-1 -: 32];
  assign prevWord  = keyWin_q[31:0];
  assign firstPass = (wordIdx_q < NK_IDX);
  assign rotSel    = (modIdx_q == 3'd0);

  key_sub_word u_sub_word (
    .word_i (prevWord),
    .rot_i  (rotSel),
    .word_o (subOut)
  );

  // Next schedule word; during the first Nk words the window just rotates the raw key through.
  always_comb begin
    newWord = oldWord ^ prevWord;
    if (firstPass) begin
      newWord = oldWord;
    end else if (modIdx_q == 3'd0) begin
      newWord = oldWord ^ subOut ^ {rcon_q, 24'h0};
    end else if (NK == 8 && modIdx_q == 3'd4) begin
      newWord = oldWord ^ subOut;
    end
  end

  // State register and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      wordIdx_q <= '0;
      modIdx_q  <= '0;
      rcon_q    <= '0;
      keyWin_q  <= '0;
      rkBuf_q   <= '0;
    end else begin
      state_q   <= state_d;
      wordIdx_q <= wordIdx_d;
      modIdx_q  <= modIdx_d;
      rcon_q    <= rcon_d;
      keyWin_q  <= keyWin_d;
      rkBuf_q   <= rkBuf_d;
    end
  end

  // FSM next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d          = state_q;
    wordIdx_d        = wordIdx_q;
    modIdx_d         = modIdx_q;
    rcon_d           = rcon_q;
    keyWin_d         = keyWin_q;
    rkBuf_d          = rkBuf_q;
    sram_write       = 1'b0;
    sram_addr        = '0;
    sram_write_value = '0;
    round_num        = '0;
    busy             = 1'b0;
    done             = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          keyWin_d  = key_in;
          wordIdx_d = '0;
          modIdx_d  = '0;
          rcon_d    = 8'h01;
          state_d   = EXPAND;
        end
      end

      EXPAND: begin
        busy     = 1'b1;
        keyWin_d = {keyWin_q[KEY_BITS-33:0], newWord};
        rkBuf_d  = {rkBuf_q[95:0], newWord};
        if (!firstPass && modIdx_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end
        modIdx_d = (modIdx_q == NK_LAST) ? 3'd0 : modIdx_q + 3'd1;
        if (wordIdx_q[1:0] == 2'd3) begin
          state_d = WRITE;
        end else begin
          wordIdx_d = wordIdx_q + 6'd1;
        end
      end

      WRITE: begin
        busy             = 1'b1;
        sram_write       = 1'b1;
        sram_addr        = ADDR_W'(BASE_ADDR) + ADDR_W'({wordIdx_q[5:2], 4'h0});
        sram_write_value = rkBuf_q;
        round_num        = wordIdx_q[5:2];
        if (sram_ready) begin
          if (wordIdx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            wordIdx_d = wordIdx_q + 6'd1;
            state_d   = EXPAND;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
`ifdef KEY_SCHED_ZEROIZE_EN
        keyWin_d = '0;
        rkBuf_d  = '0;
        rcon_d   = '0;
`else
        keyWin_d = keyWin_q;
        rkBuf_d  = rkBuf_q;
        rcon_d   = rcon_q;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/key_schedule_gen.md
Name: key_schedule_gen

Overview:
Parametrised AES key-schedule generator supporting 128/192/256-bit keys. It expands a cipher key into all Nr+1 128-bit round keys, one word per cycle. Each round key is written to the shared key SRAM at BASE_ADDR + 16*r. It sits between the key-load path and the round datapath, which reads round keys from SRAM after `done`.

Parameters:
- KEY_BITS, 128, cipher key size; legal values are 128/192/256. Nk = KEY_BITS/32; Nr = Nk+6.
- ADDR_W, 16, SRAM byte-address width.
- BASE_ADDR, 0, byte address of round key 0. Round key r is at BASE_ADDR + 16*r.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset; synchronous, active-low
- start  in  1  begin expansion; sampled only in IDLE
- key_in  in  KEY_BITS  cipher key; word 0 is key_in[KEY_BITS-1 -: 32]; captured on the accepted start
- sram_ready  in  1  SRAM accepts a write this cycle
- sram_write  out  1  write request
- sram_addr  out  ADDR_W  write byte address
- sram_write_value  out  128  round key; w[4r] in [127:96], w[4r+3] in [31:0]
- round_num  out  4  index of the round key being written
- busy  out  1  expansion in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: synchronous, active-low. All outputs 0; FSM goes to IDLE; word counter, Rcon and buffers cleared. Reset mid-expansion aborts with no further writes.
- FSM states: IDLE, EXPAND, WRITE, DONE.
- IDLE: start=1 captures key_in into an Nk-word window, sets i=0 and Rcon=0x01, then goes to EXPAND. start in any other state is ignored.
- EXPAND: produces one word w[i] per cycle.
  - i < Nk: w[i] = key word i.
  - i ≥ Nk and i%Nk==0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}. Rcon then advances by xtime (0x80 → 0x1b).
  - Nk==8 and i%Nk==4: w[i] = w[i-Nk] ^ SubWord(w[i-1]).
  - Otherwise: w[i] = w[i-Nk] ^ w[i-1].
  - Each word shifts into the window and into the 128-bit round buffer. When i%4==3, go to WRITE.
- WRITE: drives sram_write=1, sram_addr=BASE_ADDR+16*(i>>2), sram_write_value=buffer, round_num=i>>2.
  - Outputs hold stable until a cycle with sram_ready=1.
  - On acceptance: if i == 4*Nr+3 go to DONE; otherwise i++ and go to EXPAND.
  - sram_write is 0 outside WRITE, and sram_addr/value/round_num are 0 outside WRITE.
- DONE: done=1 for one cycle, then IDLE. busy=1 in EXPAND and WRITE only.
- Latency with sram_ready held at 1: busy lasts 5*(Nr+1) cycles (55/65/75), and done follows on the next cycle.
- Arithmetic: all word arithmetic is 32-bit; address arithmetic wraps modulo 2^ADDR_W.
- A KEY_BITS value outside {128,192,256} is an elaboration error.

Optional Feature:
KEY_SCHED_ZEROIZE_EN
- Defined: the key window, round buffer and Rcon are cleared to 0 in DONE, so no key material persists after completion.
- Undefined: these registers retain their last values until the next start or reset. Port-level behaviour is identical either way.

Decomposition:
- Shared package aes_pkg holds:
  - the typedef for the FSM state enum;
  - constants NK_128/192/256 and NR_128/192/256;
  - the 256-entry S-box constant;
  - the xtime function.
- One sub-module, key_sub_word, is combinational: 4 parallel S-box lookups with an optional RotWord select. It is reused later by the cipher's SubBytes.

Test Plan:
- AES-128, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, sram_ready=1:
  - 11 writes at addresses 0x00..0xA0;
  - round key 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  - done at cycle 56 after start.
- AES-192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b:
  - 13 writes;
  - round key 12 = e98ba06f_448c773c_8ecc7204_01002202.
- AES-256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4:
  - 15 writes;
  - round key 14 = fe4890d1_e6188d0b_046df344_706c631e;
  - round key 1 = 1f352c07_3b6108d7_2d9810a3_0914dff4.
- Backpressure: toggle sram_ready randomly, holding it low for 3 cycles on the first write.
  - addr, value and round_num stay stable while stalled;
  - no duplicate or dropped writes;
  - final contents match the no-stall run.
- Reset/start edges:
  - assert n_rst=0 mid-EXPAND for one cycle: all outputs 0 on the next edge and no further writes;
  - start during busy is ignored;
  - two back-to-back starts after done produce correct independent schedules.
- Zeroize (KEY_SCHED_ZEROIZE_EN defined): after DONE, internal window and buffer read 0 via hierarchical probe.
